seg_scan_ctrl: RTL and testbench

Scan controller for the board's 8-digit multiplexed seven-segment display. Takes a 32-bit hex/BCD value (8 nibbles), per-digit decimal points and a leading-zero-blank flag, and sequences the shared segment bus across the eight common-anode digits, inserting a dead gap between digits to prevent ghosting. New values are staged in a shadow register and applied only at a frame boundary, so the display never tears. Sits between the counter/datapath and the top-level `seg`/`an` pins.

---
 rtl/seg_scan_ctrl_if.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the datapath and the seven-segment scan controller.
//   en         : scan enable (0 blanks and parks the scanner)
//   load       : one-cycle strobe capturing digits/dp/lz_blank into the shadow
//   digits     : 8 nibbles, nibble i on digit i (digit 0 rightmost)
//   dp         : per-digit decimal point, bit i -> digit i
//   lz_blank   : blank leading zeros
//   an         : digit enables, active-low
//   seg        : {dp_n,g,f,e,d,c,b,a}, active-low
//   frame_done : one-cycle pulse at the end of each 8-digit frame
//   upd_pend   : shadow holds a value not yet applied
// master = datapath side, slave = scan controller.
interface seg_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [31:0] digits;
  logic [7:0]  dp;
  logic        lz_blank;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;
  logic        upd_pend;

  modport master (
    output en, load, digits, dp, lz_blank,
    input  an, seg, frame_done, upd_pend
  );

  modport slave (
    input  en, load, digits, dp, lz_blank,
    output an, seg, frame_done, upd_pend
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed common-anode seven-segment
// display. Each digit gets a slot of SCAN_DIV cycles; the first DEAD cycles
// of every slot are all-off to prevent ghosting. New values are captured into
// a shadow register on load and copied to the active register only at a frame
// boundary (idx=0, div_cnt=0, en=1), so a frame never tears.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : seg_scan_ctrl_if.slave (en/load/digits/dp/lz_blank in,
//         an/seg/frame_done/upd_pend out; all outputs registered)
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEAD     = 4
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int unsigned   DW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEAD_C  = DW'(DEAD);

  typedef enum logic [1:0] {PH_OFF, PH_GAP, PH_DRIVE} phase_t;

  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [31:0]   sh_digits, act_digits;
  logic [7:0]    sh_dp, act_dp;
  logic          sh_lz, act_lz;
  logic          upd_pend_q;
  logic [7:0]    an_q, seg_q;
  logic          fd_q;

  logic          div_wrap, boundary, lz_hide;
  logic [3:0]    nib;
  phase_t        phase;
  logic [7:0]    an_nxt, seg_nxt;
  logic          fd_nxt;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // Scan counters; parked at 0 while disabled so re-enable is a boundary.
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      idx     <= idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Shadow/active registers. At a boundary the active copy takes the shadow
  // value as it stood before any same-cycle load; that load stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_lz      <= 1'b0;
      act_digits <= '0;
      act_dp     <= '0;
      act_lz     <= 1'b0;
      upd_pend_q <= 1'b0;
    end else begin
      if (bus.load) begin
        sh_digits <= bus.digits;
        sh_dp     <= bus.dp;
        sh_lz     <= bus.lz_blank;
      end
      if (boundary && upd_pend_q) begin
        act_digits <= sh_digits;
        act_dp     <= sh_dp;
        act_lz     <= sh_lz;
      end
      if (bus.load)
        upd_pend_q <= 1'b1;
      else if (boundary)
        upd_pend_q <= 1'b0;
    end
  end

  always_comb begin
    div_wrap = (div_cnt == DIV_MAX);
    boundary = bus.en && (idx == 3'd0) && (div_cnt == '0);
    nib      = act_digits[{idx, 2'b00} +: 4];

    // Digit idx is a leading zero when it and every higher nibble are zero.
    lz_hide = act_lz && (idx != 3'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      if ((i >= 32'(idx)) && (act_digits[i*4 +: 4] != 4'd0))
        lz_hide = 1'b0;
    end

    if (!bus.en)
      phase = PH_OFF;
    else if ((div_cnt < DEAD_C) || lz_hide)
      phase = PH_GAP;
    else
      phase = PH_DRIVE;

    an_nxt  = '1;
    seg_nxt = '1;
    if (phase == PH_DRIVE) begin
      an_nxt  = ~(8'h01 << idx);
      seg_nxt = {~act_dp[idx], decode(nib)};
    end
    fd_nxt = bus.en && (idx == 3'd7) && div_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= '1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
      fd_q  <= fd_nxt;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = fd_q;
  assign bus.upd_pend   = upd_pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=8, DEAD=2. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.SCAN_DIV(8), .DEAD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_off(input string tag, input logic exp_pend);
    check({tag, " an"}, 32'(bus.an), 32'hFF);
    check({tag, " seg"}, 32'(bus.seg), 32'hFF);
    check({tag, " fd"}, 32'(bus.frame_done), 32'h0);
    check({tag, " pend"}, 32'(bus.upd_pend), 32'(exp_pend));
  endtask

  // Runs nslots digit slots from a frame boundary. segs byte s = expected seg
  // of slot s (FF = blanked slot, an also FF). pmask bit s = expected upd_pend.
  // If ld_slot matches, a one-cycle load is issued on the slot's first edge.
  task automatic run_frame(input logic [63:0] segs, input logic [7:0] pmask,
                           input int nslots, input int ld_slot,
                           input logic [31:0] ld_d, input logic [7:0] ld_dp,
                           input logic ld_lz);
    logic [7:0] es, ea;
    for (int s = 0; s < nslots; s++) begin
      if (s == ld_slot) begin
        bus.digits   = ld_d;
        bus.dp       = ld_dp;
        bus.lz_blank = ld_lz;
        bus.load     = 1'b1;
      end
      es = segs[s*8 +: 8];
      ea = (es == 8'hFF) ? 8'hFF : ~(8'h01 << s);
      for (int c = 0; c < 8; c++) begin
        tick();
        bus.load = 1'b0;
        if (c < 2) begin
          check($sformatf("an s%0d c%0d", s, c), 32'(bus.an), 32'hFF);
          check($sformatf("seg s%0d c%0d", s, c), 32'(bus.seg), 32'hFF);
        end else begin
          check($sformatf("an s%0d c%0d", s, c), 32'(bus.an), 32'(ea));
          check($sformatf("seg s%0d c%0d", s, c), 32'(bus.seg), 32'(es));
        end
        check($sformatf("fd s%0d c%0d", s, c), 32'(bus.frame_done),
              (s == 7 && c == 7) ? 32'h1 : 32'h0);
        check($sformatf("pend s%0d c%0d", s, c), 32'(bus.upd_pend), 32'(pmask[s]));
      end
    end
  endtask

  // First four cycles of a slot: two gap cycles then two driven cycles.
  task automatic part_slot(input string tag, input logic [7:0] ea, input logic [7:0] es);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("%s an c%0d", tag, c), 32'(bus.an), (c < 2) ? 32'hFF : 32'(ea));
      check($sformatf("%s seg c%0d", tag, c), 32'(bus.seg), (c < 2) ? 32'hFF : 32'(es));
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.digits   = '0;
    bus.dp       = '0;
    bus.lz_blank = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_off($sformatf("rst%0d", i), 1'b0);
    end
    rst = 1'b0;
    tick();
    check_off("idle", 1'b0);

    // Load while disabled: pending, display stays dark.
    bus.digits = 32'h01234567;
    bus.load   = 1'b1;
    tick();
    bus.load = 1'b0;
    check_off("preload", 1'b1);

    bus.en = 1'b1;
    // Frame 1: 01234567; load 11111111 in slot 4 does not tear this frame.
    run_frame(64'hC0F9_A4B0_9992_82F8, 8'hF0, 8, 4, 32'h11111111, 8'h00, 1'b0);
    // Frame 2: all ones; load X (00000900, lz) in slot 6.
    run_frame(64'hF9F9_F9F9_F9F9_F9F9, 8'hC0, 8, 6, 32'h00000900, 8'h00, 1'b1);
    // Frame 3: shows X; load Y on the boundary cycle itself, stays pending.
    run_frame(64'hFFFF_FFFF_FF90_C0C0, 8'hFF, 8, 0, 32'h00008000, 8'h08, 1'b0);
    // Frame 4: shows Y (digit 3 = 8 with dp -> 00); stop after slot 4.
    run_frame(64'hC0C0_C0C0_00C0_C0C0, 8'h00, 5, -1, 32'h0, 8'h00, 1'b0);

    // Drop en mid-DRIVE in slot 5.
    part_slot("s5", 8'hDF, 8'hC0);
    bus.en = 1'b0;
    tick();
    check_off("en_off", 1'b0);
    bus.digits   = 32'h11111111;
    bus.dp       = 8'h00;
    bus.lz_blank = 1'b0;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    check_off("off_load", 1'b1);
    tick();
    check_off("off_hold", 1'b1);

    // Re-enable: that cycle is a boundary, pending ones applied.
    bus.en = 1'b1;
    run_frame(64'h0000_0000_0000_00F9, 8'h00, 1, -1, 32'h0, 8'h00, 1'b0);
    part_slot("s1", 8'hFD, 8'hF9);

    // Reset mid-DRIVE, with a competing load that must be ignored.
    rst          = 1'b1;
    bus.digits   = 32'h22222222;
    bus.load     = 1'b1;
    tick();
    check_off("rst_mid", 1'b0);
    rst      = 1'b0;
    bus.load = 1'b0;
    // Active register cleared: zeros shown, no dp.
    run_frame(64'h0000_0000_0000_C0C0, 8'h00, 2, -1, 32'h0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
